// File: rtl/gpio_pkg.sv
// Shared GPIO register-map constants, also used by the core's memory decoder.
package gpio_pkg;

  localparam logic [31:0] GPIO_BASE_ADDR = 32'h1001_0000;

  // Register offsets in addr[3:2] units
  localparam logic [1:0] GPIO_OFF_IN   = 2'd0;
  localparam logic [1:0] GPIO_OFF_OUT  = 2'd1;
  localparam logic [1:0] GPIO_OFF_EDGE = 2'd2;
  localparam logic [1:0] GPIO_OFF_RAW  = 2'd3;

endpackage

// File: rtl/gpio_debounce.sv
// One GPIO input pin: two-flop synchronizer, debounce counter, accepted level
// and a single-cycle pulse on the accepted 0->1 transition.
module gpio_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Pulse on the accepting cycle so the edge bit lands together with the level
  assign rise  = sync2 && !stable && (cnt == LAST);
  assign raw   = sync2;
  assign level = stable;

endmodule

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO: debounced inputs, rising-edge capture (W1C) and an
// output register, decoded from the core's data-memory bus.
module gpio_mmio
  import gpio_pkg::*;
#(
  parameter int unsigned       GPIO_W          = 8,
  parameter logic [31:0]       BASE_ADDR       = GPIO_BASE_ADDR,
  parameter int unsigned       DEBOUNCE_CYCLES = 4,
  parameter logic [GPIO_W-1:0] OUT_RESET       = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  input  logic              we,
  output logic [31:0]       rdata,
  output logic              hit,
  input  logic [GPIO_W-1:0] GPIO_i,
  output logic [GPIO_W-1:0] GPIO_o,
  output logic              irq
);

  logic [GPIO_W-1:0] raw;
  logic [GPIO_W-1:0] level;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] edge_q;
  logic [GPIO_W-1:0] edge_clr;
  logic [1:0]        off;
  logic              wr_out;
  logic              wr_edge;
  logic              unused_ok;

  for (genvar i = 0; i < GPIO_W; i++) begin : g_pin
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk  (clk),
      .rst  (rst),
      .pin  (GPIO_i[i]),
      .raw  (raw[i]),
      .level(level[i]),
      .rise (rise[i])
    );
  end

  assign hit      = (addr[31:4] == BASE_ADDR[31:4]);
  assign off      = addr[3:2];
  assign wr_out   = we && hit && (off == GPIO_OFF_OUT);
  assign wr_edge  = we && hit && (off == GPIO_OFF_EDGE);
  assign edge_clr = wr_edge ? wdata[GPIO_W-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      GPIO_o <= OUT_RESET;
      edge_q <= '0;
    end else begin
      if (wr_out) begin
        GPIO_o <= wdata[GPIO_W-1:0];
      end
      // A new rise overrides a same-cycle clear of that bit
      edge_q <= (edge_q & ~edge_clr) | rise;
    end
  end

  always_comb begin
    rdata = '0;
    if (hit) begin
      unique case (off)
        GPIO_OFF_IN:   rdata[GPIO_W-1:0] = level;
        GPIO_OFF_OUT:  rdata[GPIO_W-1:0] = GPIO_o;
        GPIO_OFF_EDGE: rdata[GPIO_W-1:0] = edge_q;
        GPIO_OFF_RAW:  rdata[GPIO_W-1:0] = raw;
        default:       rdata = '0;
      endcase
    end
  end

  assign irq       = |edge_q;
  assign unused_ok = ^{addr[1:0], wdata};

endmodule

// File: tb/tb_gpio_mmio.sv
// Directed bench for gpio_mmio with default parameters (8 pins, 4-cycle debounce).
module tb_gpio_mmio;

  localparam logic [31:0] A_IN   = 32'h1001_0000;
  localparam logic [31:0] A_OUT  = 32'h1001_0004;
  localparam logic [31:0] A_EDGE = 32'h1001_0008;
  localparam logic [31:0] A_RAW  = 32'h1001_000C;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;
  logic        hit;
  logic [7:0]  GPIO_i;
  logic [7:0]  GPIO_o;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;

  gpio_mmio #(
    .GPIO_W(8),
    .BASE_ADDR(32'h1001_0000),
    .DEBOUNCE_CYCLES(4),
    .OUT_RESET(8'h00)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .wdata (wdata),
    .we    (we),
    .rdata (rdata),
    .hit   (hit),
    .GPIO_i(GPIO_i),
    .GPIO_o(GPIO_o),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
    addr = a;
    we   = 1'b0;
    #1;
    chk(tag, rdata, exp);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    tick();
    we    = 1'b0;
    wdata = '0;
  endtask

  initial begin
    rst    = 1'b1;
    addr   = A_IN;
    wdata  = '0;
    we     = 1'b0;
    GPIO_i = 8'h00;

    // Reset state
    tick(2);
    rd("rst_in", A_IN, 32'h0);
    rd("rst_out", A_OUT, 32'h0);
    rd("rst_edge", A_EDGE, 32'h0);
    rd("rst_raw", A_RAW, 32'h0);
    chk("rst_gpio_o", {24'h0, GPIO_o}, 32'h0);
    chk("rst_irq", {31'h0, irq}, 32'h0);
    rst = 1'b0;
    tick();

    // Input latency: RAW after 2 edges, IN/EDGE after 6
    GPIO_i = 8'h0F;
    tick();
    rd("raw_e1", A_RAW, 32'h0);
    tick();
    rd("raw_e2", A_RAW, 32'h0F);
    rd("in_e2", A_IN, 32'h0);
    tick(3);
    rd("in_e5", A_IN, 32'h0);
    rd("edge_e5", A_EDGE, 32'h0);
    chk("irq_e5", {31'h0, irq}, 32'h0);
    tick();
    rd("in_e6", A_IN, 32'h0F);
    rd("edge_e6", A_EDGE, 32'h0F);
    chk("irq_e6", {31'h0, irq}, 32'h1);

    // 3-cycle glitch on bit 7 is filtered
    GPIO_i = 8'h8F;
    tick(2);
    rd("glitch_raw", A_RAW, 32'h8F);
    tick();
    GPIO_i = 8'h0F;
    tick(7);
    rd("glitch_in", A_IN, 32'h0F);
    rd("glitch_edge", A_EDGE, 32'h0F);
    rd("glitch_raw_back", A_RAW, 32'h0F);

    // OUT register and read-only IN/RAW
    wr(A_OUT, 32'hFFFF_FFA5);
    chk("gpio_o_a5", {24'h0, GPIO_o}, 32'hA5);
    rd("out_a5", A_OUT, 32'h0000_00A5);
    wr(A_IN, 32'hFFFF_FFFF);
    rd("in_ro", A_IN, 32'h0F);
    wr(A_RAW, 32'h0000_0000);
    rd("raw_ro", A_RAW, 32'h0F);

    // W1C
    wr(A_EDGE, 32'h3);
    rd("edge_w1c", A_EDGE, 32'h0C);
    chk("irq_w1c", {31'h0, irq}, 32'h1);

    // Set wins over clear on the same edge
    wr(A_EDGE, 32'hFF);
    rd("edge_clr_all", A_EDGE, 32'h0);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    GPIO_i = 8'h0B;
    tick(6);
    rd("in_fall", A_IN, 32'h0B);
    rd("edge_fall", A_EDGE, 32'h0);
    GPIO_i = 8'h0F;
    tick(5);
    rd("edge_pre_rise", A_EDGE, 32'h0);
    wr(A_EDGE, 32'h4);
    rd("edge_set_wins", A_EDGE, 32'h04);
    rd("in_rise", A_IN, 32'h0F);

    // Decode window
    addr = 32'h1001_0010;
    #1;
    chk("hit_out", {31'h0, hit}, 32'h0);
    chk("rdata_out", rdata, 32'h0);
    wr(32'h1001_0014, 32'h0);
    chk("gpio_o_keep", {24'h0, GPIO_o}, 32'hA5);
    wr(32'h1001_0018, 32'hFF);
    rd("edge_keep", A_EDGE, 32'h04);
    addr = A_EDGE;
    #1;
    chk("hit_in", {31'h0, hit}, 32'h1);
    rd("byte_offset", 32'h1001_0007, 32'hA5);

    // Reset mid-debounce restarts qualification
    GPIO_i = 8'h1F;
    tick(4);
    rd("pre_rst_in", A_IN, 32'h0F);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    rd("post_rst_in", A_IN, 32'h0);
    rd("post_rst_edge", A_EDGE, 32'h0);
    chk("post_rst_gpio_o", {24'h0, GPIO_o}, 32'h0);
    chk("post_rst_irq", {31'h0, irq}, 32'h0);
    tick(5);
    rd("requal_in_e5", A_IN, 32'h0);
    tick();
    rd("requal_in_e6", A_IN, 32'h1F);
    rd("requal_edge_e6", A_EDGE, 32'h1F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
